// File: rtl/arb_pkg.sv
// Shared types for the round-robin resource arbiter.
// FSM encoding used by the top-level controller.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority search: first eligible requester at or after rr_ptr,
// wrapping from N_REQ-1 back to 0.
module rr_priority_pick #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             found,
    output logic [ID_W-1:0]  win_id
);

    int unsigned idx;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (eligible[idx]) begin
                found  = 1'b1;
                win_id = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter for one shared resource with level req/grant handshake,
// mandatory gap between owners and a hold-time watchdog.
module rr_resource_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic [N_REQ-1:0] blocked,
    output logic             timeout_pulse,
    output logic [ID_W-1:0]  timeout_id
);

    localparam int HC_W = $clog2(MAX_HOLD + 1);

    arb_state_e       state, state_n;
    logic [N_REQ-1:0] grant_n;
    logic [ID_W-1:0]  grant_id_n;
    logic [ID_W-1:0]  rr_ptr, rr_ptr_n;
    logic [HC_W-1:0]  hold_cnt, hold_cnt_n;
    logic [N_REQ-1:0] blocked_n;
    logic             timeout_pulse_n;
    logic [ID_W-1:0]  timeout_id_n;

    logic [N_REQ-1:0] eligible;
    logic             found;
    logic [ID_W-1:0]  win_id;

    assign eligible = req & ~blocked;
    assign busy     = |grant;

    rr_priority_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (found),
        .win_id   (win_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            grant_id      <= '0;
            rr_ptr        <= '0;
            hold_cnt      <= '0;
            blocked       <= '0;
            timeout_pulse <= 1'b0;
            timeout_id    <= '0;
        end else begin
            state         <= state_n;
            grant         <= grant_n;
            grant_id      <= grant_id_n;
            rr_ptr        <= rr_ptr_n;
            hold_cnt      <= hold_cnt_n;
            blocked       <= blocked_n;
            timeout_pulse <= timeout_pulse_n;
            timeout_id    <= timeout_id_n;
        end
    end

    always_comb begin
        state_n         = state;
        grant_n         = grant;
        grant_id_n      = grant_id;
        rr_ptr_n        = rr_ptr;
        hold_cnt_n      = hold_cnt;
        timeout_pulse_n = 1'b0;
        timeout_id_n    = timeout_id;
        // A block lasts only until the requester is seen idle.
        blocked_n       = blocked & req;

        unique case (state)
            IDLE: begin
                if (en && found) begin
                    state_n    = GRANT;
                    grant_n    = N_REQ'(1) << win_id;
                    grant_id_n = win_id;
                    rr_ptr_n   = (win_id == ID_W'(N_REQ - 1)) ? '0
                                                              : win_id + 1'b1;
                    hold_cnt_n = '0;
                end
            end
            GRANT: begin
                if (hold_cnt != HC_W'(MAX_HOLD))
                    hold_cnt_n = hold_cnt + 1'b1;
                // Voluntary release wins over the watchdog on the same cycle.
                if (!req[grant_id]) begin
                    state_n = GAP;
                    grant_n = '0;
                end else if (hold_cnt == HC_W'(MAX_HOLD - 1)) begin
                    state_n             = GAP;
                    grant_n             = '0;
                    timeout_pulse_n     = 1'b1;
                    timeout_id_n        = grant_id;
                    blocked_n[grant_id] = 1'b1;
                end
            end
            GAP: begin
                state_n = IDLE;
                grant_n = '0;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

endmodule
